// File: rtl/clk_phase_pkg.sv
// Shared types for the eclk/eclksync phase alignment controller.
//   state_t      : search FSM states
//   phase_code_t : 2-bit filtered phase code {eclksync/2 sample, eclk sample}
//   PREV_CODE_DEF / TARGET_CODE_DEF : default code pair that marks the lock edge
package clk_phase_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        DECIDE,
        STEP,
        NEXT,
        DONE
    } state_t;

    typedef logic [1:0] phase_code_t;

    localparam phase_code_t PREV_CODE_DEF   = 2'b00;
    localparam phase_code_t TARGET_CODE_DEF = 2'b01;

endpackage

// File: rtl/clk_phase_filter.sv
// Phase sample synchroniser and majority filter.
//   sclk, reset : clock, async active-high reset
//   phase_in    : raw 2-bit samples for all channels, ch i at [2i+1:2i]
//   ch          : channel currently being measured
//   clear       : zero the sample/ones counters
//   enable      : accumulate one synchronised sample of channel ch
//   valid       : high on the cycle the final sample of a window is taken
//   code        : majority code of the accumulated window (read after valid)
module clk_phase_filter
    import clk_phase_pkg::*;
#(
    parameter int NCH        = 1,
    parameter int FILTER_LEN = 16,
    parameter int CH_W       = 1
) (
    input  logic              sclk,
    input  logic              reset,
    input  logic [2*NCH-1:0]  phase_in,
    input  logic [CH_W-1:0]   ch,
    input  logic              clear,
    input  logic              enable,
    output logic              valid,
    output phase_code_t       code
);

    localparam int               CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] HALF     = CNT_W'(FILTER_LEN / 2);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FILTER_LEN - 1);

    // Every channel is synchronised all the time, so switching channels
    // never exposes stale flop contents to the next measurement window.
    logic [NCH-1:0][1:0]     sync_q1, sync_q2;
    logic [1:0]              sample;
    logic [CNT_W-1:0]        cnt;
    logic [1:0][CNT_W-1:0]   ones;

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= phase_in;
            sync_q2 <= sync_q1;
        end
    end

    always_comb begin
        sample = '0;
        for (int i = 0; i < NCH; i++)
            if (ch == CH_W'(i)) sample = sync_q2[i];
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            ones <= '0;
        end else if (clear) begin
            cnt  <= '0;
            ones <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
            for (int b = 0; b < 2; b++)
                ones[b] <= ones[b] + CNT_W'(sample[b]);
        end
    end

    assign valid = enable && (cnt == LAST_IDX);

    // A tie (exactly half ones) resolves to 1.
    always_comb begin
        for (int b = 0; b < 2; b++)
            code[b] = (ones[b] >= HALF);
    end

endmodule

// File: rtl/clk_phase_align.sv
// Multi-channel eclk/eclksync phase alignment controller (sclk domain).
//   sclk, reset : clock, async active-high reset
//   start       : 1-cycle pulse, begins a search over all channels (ignored while busy)
//   phase_in    : raw phase samples, ch i at [2i+1:2i]
//   phase_step  : per-channel step request, STEP_PULSE cycles wide, one-hot or zero
//   busy / done : search running / search finished (done held until next start)
//   lock / fail : per-channel result, exactly one set per channel after done
//   code_out    : last filtered code per channel
//   cur_steps   : steps taken on the channel currently (or last) searched
module clk_phase_align
    import clk_phase_pkg::*;
#(
    parameter int          NCH         = 1,
    parameter int          FILTER_LEN  = 16,
    parameter int          SETTLE_CYC  = 32,
    parameter int          STEP_PULSE  = 4,
    parameter int          MAX_STEPS   = 64,
    parameter phase_code_t PREV_CODE   = PREV_CODE_DEF,
    parameter phase_code_t TARGET_CODE = TARGET_CODE_DEF,
    localparam int         STEP_W      = $clog2(MAX_STEPS + 1)
) (
    input  logic              sclk,
    input  logic              reset,
    input  logic              start,
    input  logic [2*NCH-1:0]  phase_in,
    output logic [NCH-1:0]    phase_step,
    output logic              busy,
    output logic              done,
    output logic [NCH-1:0]    lock,
    output logic [NCH-1:0]    fail,
    output logic [2*NCH-1:0]  code_out,
    output logic [STEP_W-1:0] cur_steps
);

    localparam int                CH_W       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int                TMR_MAX    = (SETTLE_CYC > STEP_PULSE) ? SETTLE_CYC : STEP_PULSE;
    localparam int                TMR_W      = $clog2(TMR_MAX + 1);
    localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(NCH - 1);
    localparam logic [STEP_W-1:0] STEP_MAX   = STEP_W'(MAX_STEPS);
    localparam logic [TMR_W-1:0]  SETTLE_END = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0]  PULSE_END  = TMR_W'(STEP_PULSE - 1);

    state_t              state, state_nxt;
    logic [CH_W-1:0]     ch;
    logic [STEP_W-1:0]   steps;
    logic [TMR_W-1:0]    timer;
    logic                first;
    phase_code_t         prev;
    logic [NCH-1:0][1:0] code_q;
    logic                filt_clear, filt_en, filt_valid;
    phase_code_t         filt_code;
    logic                is_lock;

    clk_phase_filter #(
        .NCH        (NCH),
        .FILTER_LEN (FILTER_LEN),
        .CH_W       (CH_W)
    ) u_filter (
        .sclk     (sclk),
        .reset    (reset),
        .phase_in (phase_in),
        .ch       (ch),
        .clear    (filt_clear),
        .enable   (filt_en),
        .valid    (filt_valid),
        .code     (filt_code)
    );

    // The first measurement of a channel only seeds prev, so a lock always
    // needs at least one step.
    assign is_lock   = !first && (prev == PREV_CODE) && (filt_code == TARGET_CODE);
    assign busy      = (state != IDLE) && (state != DONE);
    assign code_out  = code_q;
    assign cur_steps = steps;

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // phase_step is decoded from the state register so it falls the moment
    // reset forces the FSM back to IDLE.
    always_comb begin
        state_nxt  = state;
        filt_clear = 1'b1;
        filt_en    = 1'b0;
        phase_step = '0;
        case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (timer == SETTLE_END) state_nxt = MEASURE;
            MEASURE: begin
                filt_clear = 1'b0;
                filt_en    = 1'b1;
                if (filt_valid) state_nxt = DECIDE;
            end
            DECIDE: begin
                if (first)                           state_nxt = STEP;
                else if (is_lock || steps == STEP_MAX) state_nxt = NEXT;
                else                                 state_nxt = STEP;
            end
            STEP: begin
                phase_step = NCH'(1) << ch;
                if (timer == PULSE_END) state_nxt = SETTLE;
            end
            NEXT:    state_nxt = (ch == LAST_CH) ? DONE : SETTLE;
            DONE:    state_nxt = start ? SETTLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            ch     <= '0;
            steps  <= '0;
            timer  <= '0;
            first  <= 1'b0;
            prev   <= '0;
            code_q <= '0;
            lock   <= '0;
            fail   <= '0;
            done   <= 1'b0;
        end else begin
            // Shared SETTLE/STEP timer restarts on every state change and
            // saturates so it never wraps while idle.
            if (state_nxt != state) timer <= '0;
            else if (timer != '1)   timer <= timer + 1'b1;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        ch    <= '0;
                        steps <= '0;
                        first <= 1'b1;
                        lock  <= '0;
                        fail  <= '0;
                        done  <= 1'b0;
                    end
                end
                DECIDE: begin
                    for (int i = 0; i < NCH; i++) begin
                        if (ch == CH_W'(i)) begin
                            code_q[i] <= filt_code;
                            if (is_lock)                          lock[i] <= 1'b1;
                            else if (!first && steps == STEP_MAX) fail[i] <= 1'b1;
                        end
                    end
                    if (!is_lock) prev <= filt_code;
                    first <= 1'b0;
                end
                STEP: begin
                    if (state_nxt == SETTLE && steps != STEP_MAX) steps <= steps + 1'b1;
                end
                NEXT: begin
                    if (ch == LAST_CH) begin
                        done <= 1'b1;
                    end else begin
                        ch    <= ch + 1'b1;
                        steps <= '0;
                        first <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
